axis_frame_serializer: RTL

- TX-side successor to the single-width word-to-byte path.
- Accepts AXI-Stream beats of parametrised width with tkeep/tlast, buffers them in a parametrised-depth word FIFO, and serialises valid bytes, lane 0 first, into one byte per accepted cycle toward the 8b/10b encoder.
- Adds frame delimiting with K-characters (SOF/EOF), idle comma fill, a minimum inter-frame gap, and encoder back-pressure.
- Single clock domain.

---
 rtl/axis_frame_serializer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_frame_serializer.sv
// axis_frame_serializer
//
// Takes AXI-Stream beats (tdata/tkeep/tlast) into a small word FIFO and
// serialises the kept bytes, lane 0 first, one symbol per consume edge toward
// an 8b/10b encoder.  Frames are wrapped in K27.7 (SOF) / K29.7 (EOF).  K28.5
// fills idle time and data underruns.  At least IDLE_MIN K28.5 symbols are
// consumed between an EOF and the following SOF.
//
// Ports
//   m_axis_aclk, m_axis_reset_n   clock, asynchronous active-low reset
//   m_axis_tdata/tkeep/tlast      beat payload, lane i = tdata[8i+7:8i]
//   m_axis_valid / m_axis_ready   beat handshake (ready from registered state only)
//   o_to_encoder, o_is_k          registered symbol presented to the encoder
//   i_enc_ready                   encoder consumes the current symbol on this edge
//   o_busy                        frame in progress or FIFO holds words
//   o_frames_sent                 count of consumed EOF symbols (wraps)
module axis_frame_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_MIN   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    m_axis_aclk,
    input  logic                    m_axis_reset_n,
    input  logic [DATA_WIDTH-1:0]   m_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    input  logic                    m_axis_tlast,
    input  logic                    m_axis_valid,
    output logic                    m_axis_ready,
    output logic [7:0]              o_to_encoder,
    output logic                    o_is_k,
    input  logic                    i_enc_ready,
    output logic                    o_busy,
    output logic [CNT_WIDTH-1:0]    o_frames_sent
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [7:0]  K_IDLE   = 8'hBC;
    localparam logic [7:0]  K_SOF    = 8'hFB;
    localparam logic [7:0]  K_EOF    = 8'hFD;
    localparam logic [7:0]  IDLE_SAT = 8'(IDLE_MIN);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_EOF} state_t;

    function automatic logic [7:0] idle_sat_inc(input logic [7:0] v);
        return (v >= IDLE_SAT) ? IDLE_SAT : v + 8'd1;
    endfunction

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [BYTES-1:0]      fifo_keep [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fifo_count;
    logic                  fifo_empty;

    logic                  rst_done;
    state_t                state;
    logic [PW-1:0]         byte_ptr;
    logic [7:0]            idle_cnt;

    logic [DATA_WIDTH-1:0] head_data;
    logic [BYTES-1:0]      head_keep;
    logic                  head_last;
    logic                  lane_found;
    logic                  lane_more;
    logic [PW-1:0]         lane_sel;
    logic [7:0]            head_byte;
    logic                  push;
    logic                  pop;

    assign fifo_empty   = (fifo_count == '0);
    assign m_axis_ready = rst_done && (fifo_count != FULL_CNT);
    assign o_busy       = (state != ST_IDLE) || !fifo_empty;

    // A beat with no kept lanes that does not end a frame carries nothing to
    // serialise, so it is dropped at the input instead of occupying a FIFO slot.
    assign push = m_axis_valid && m_axis_ready && ((|m_axis_tkeep) || m_axis_tlast);

    assign head_data = fifo_data[rd_ptr];
    assign head_keep = fifo_keep[rd_ptr];
    assign head_last = fifo_last[rd_ptr];

    // byte_ptr marks the lowest lane not yet sent; pick the first kept lane at
    // or above it and note whether another kept lane follows in the same word.
    always_comb begin
        lane_found = 1'b0;
        lane_more  = 1'b0;
        lane_sel   = '0;
        head_byte  = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (head_keep[i] && (i >= int'(byte_ptr))) begin
                if (!lane_found) begin
                    lane_found = 1'b1;
                    lane_sel   = PW'(i);
                    head_byte  = head_data[8*i +: 8];
                end else begin
                    lane_more = 1'b1;
                end
            end
        end
    end

    // Word leaves the FIFO when its last kept byte is loaded, or when it is
    // an empty closing beat (no kept lane at all).
    assign pop = i_enc_ready && (state == ST_DATA) && !fifo_empty && !(lane_found && lane_more);

    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (push) begin
            fifo_data[wr_ptr] <= m_axis_tdata;
            fifo_keep[wr_ptr] <= m_axis_tkeep;
            fifo_last[wr_ptr] <= m_axis_tlast;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Symbol FSM: everything here advances only when the encoder takes the
    // current symbol; the next symbol is loaded on that same edge.
    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            state         <= ST_IDLE;
            byte_ptr      <= '0;
            idle_cnt      <= IDLE_SAT;
            o_to_encoder  <= K_IDLE;
            o_is_k        <= 1'b1;
            o_frames_sent <= '0;
        end else if (i_enc_ready) begin
            if (o_is_k && (o_to_encoder == K_EOF))
                o_frames_sent <= o_frames_sent + 1'b1;
            case (state)
                ST_IDLE: begin
                    byte_ptr <= '0;
                    if (!fifo_empty && (idle_cnt >= IDLE_SAT)) begin
                        o_to_encoder <= K_SOF;
                        o_is_k       <= 1'b1;
                        state        <= ST_DATA;
                    end else begin
                        o_to_encoder <= K_IDLE;
                        o_is_k       <= 1'b1;
                        idle_cnt     <= idle_sat_inc(idle_cnt);
                    end
                end
                ST_DATA: begin
                    if (fifo_empty) begin
                        // underrun filler, frame stays open
                        o_to_encoder <= K_IDLE;
                        o_is_k       <= 1'b1;
                    end else if (!lane_found) begin
                        // empty closing beat: EOF directly after the last byte
                        o_to_encoder <= K_EOF;
                        o_is_k       <= 1'b1;
                        idle_cnt     <= '0;
                        byte_ptr     <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        o_to_encoder <= head_byte;
                        o_is_k       <= 1'b0;
                        if (lane_more) begin
                            byte_ptr <= lane_sel + 1'b1;
                        end else begin
                            byte_ptr <= '0;
                            if (head_last) state <= ST_EOF;
                        end
                    end
                end
                ST_EOF: begin
                    o_to_encoder <= K_EOF;
                    o_is_k       <= 1'b1;
                    idle_cnt     <= '0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
